// File: rtl/wave_cfg_sched.sv
// wave_cfg_sched -- configuration scheduler for the sine generator.
//
// Takes frequency/amplitude commands from two requesters: debounced board
// keys (A) and LCD touch keys (B). It keeps a shadow copy of the settings.
// A new setting is committed to the DDS/scaling datapath only on a DDS phase
// wrap, so the waveform never changes mid-cycle. If no phase wrap arrives
// within WRAP_TIMEOUT cycles, the commit is forced.
//
// Optional feature macro: WAVE_CFG_WRAP_EN
//   defined   : up/down steps wrap around at the limits (MAX->MIN, MIN->MAX)
//   undefined : up/down steps saturate at the limits
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   req_a_valid  requester A command valid
//   req_a_cmd    requester A command (0 NOP, 1 FREQ_UP, 2 FREQ_DN, 3 AMP_UP,
//                4 AMP_DN, 5 DEFAULTS, 6/7 NOP)
//   req_a_ready  requester A may present a command
//   req_b_valid  requester B command valid
//   req_b_cmd    requester B command
//   req_b_ready  requester B may present a command
//   phase_wrap   one-cycle strobe at DDS phase zero
//   freq_out     committed frequency step (x100 Hz)
//   amp_out      committed amplitude code (x0.1 Vpp)
//   cfg_update   one-cycle pulse when freq_out/amp_out change
//   busy         high whenever a command is being processed
module wave_cfg_sched #(
  parameter int FREQ_MIN     = 1,
  parameter int FREQ_MAX     = 30,
  parameter int FREQ_INIT    = 10,
  parameter int AMP_MIN      = 10,
  parameter int AMP_MAX      = 20,
  parameter int AMP_INIT     = 10,
  parameter int WRAP_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a_valid,
  input  logic [2:0] req_a_cmd,
  output logic       req_a_ready,
  input  logic       req_b_valid,
  input  logic [2:0] req_b_cmd,
  output logic       req_b_ready,
  input  logic       phase_wrap,
  output logic [4:0] freq_out,
  output logic [4:0] amp_out,
  output logic       cfg_update,
  output logic       busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam logic [2:0] CMD_FREQ_UP  = 3'd1;
  localparam logic [2:0] CMD_FREQ_DN  = 3'd2;
  localparam logic [2:0] CMD_AMP_UP   = 3'd3;
  localparam logic [2:0] CMD_AMP_DN   = 3'd4;
  localparam logic [2:0] CMD_DEFAULTS = 3'd5;

  localparam logic [4:0] F_MIN  = 5'(FREQ_MIN);
  localparam logic [4:0] F_MAX  = 5'(FREQ_MAX);
  localparam logic [4:0] F_INIT = 5'(FREQ_INIT);
  localparam logic [4:0] A_MIN  = 5'(AMP_MIN);
  localparam logic [4:0] A_MAX  = 5'(AMP_MAX);
  localparam logic [4:0] A_INIT = 5'(AMP_INIT);

  localparam int CNT_W = (WRAP_TIMEOUT > 1) ? $clog2(WRAP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WRAP_TIMEOUT - 1);

  // Step one unit up. The limit is checked before the add, so the value
  // never passes through 31.
  function automatic logic [4:0] step_up(input logic [4:0] v,
                                         input logic [4:0] lo,
                                         input logic [4:0] hi);
`ifdef WAVE_CFG_WRAP_EN
    return (v >= hi) ? lo : v + 5'd1;
`else
    return (v >= hi) ? hi : v + 5'd1;
`endif
  endfunction

  // Step one unit down. The limit is checked before the subtract, so the
  // value never passes through 0.
  function automatic logic [4:0] step_dn(input logic [4:0] v,
                                         input logic [4:0] lo,
                                         input logic [4:0] hi);
`ifdef WAVE_CFG_WRAP_EN
    return (v <= lo) ? hi : v - 5'd1;
`else
    return (v <= lo) ? lo : v - 5'd1;
`endif
  endfunction

  // Next {freq, amp} for a command applied to the current shadow values.
  function automatic logic [9:0] next_cfg(input logic [2:0] cmd,
                                          input logic [4:0] f,
                                          input logic [4:0] a);
    logic [4:0] nf;
    logic [4:0] na;
    nf = f;
    na = a;
    case (cmd)
      CMD_FREQ_UP:  nf = step_up(f, F_MIN, F_MAX);
      CMD_FREQ_DN:  nf = step_dn(f, F_MIN, F_MAX);
      CMD_AMP_UP:   na = step_up(a, A_MIN, A_MAX);
      CMD_AMP_DN:   na = step_dn(a, A_MIN, A_MAX);
      CMD_DEFAULTS: begin
        nf = F_INIT;
        na = A_INIT;
      end
      default: begin
        nf = f;
        na = a;
      end
    endcase
    return {nf, na};
  endfunction

  logic [1:0]       state;
  logic             pref_b;      // 1: B wins the next simultaneous request
  logic [2:0]       cmd_lat;
  logic [4:0]       shadow_freq;
  logic [4:0]       shadow_amp;
  logic [CNT_W-1:0] wrap_cnt;
  logic             grant_a;
  logic             grant_b;
  logic [4:0]       calc_freq;
  logic [4:0]       calc_amp;

  // Grant logic: only in IDLE, one requester per edge, pointer breaks ties.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == S_IDLE) begin
      if (req_a_valid && req_b_valid) begin
        grant_a = ~pref_b;
        grant_b = pref_b;
      end else begin
        grant_a = req_a_valid;
        grant_b = req_b_valid;
      end
    end else begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
  end

  // Candidate shadow values for the latched command.
  always_comb begin
    {calc_freq, calc_amp} = next_cfg(cmd_lat, shadow_freq, shadow_amp);
  end

  // Scheduler FSM, shadow registers and committed outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pref_b      <= 1'b0;
      cmd_lat     <= 3'd0;
      shadow_freq <= F_INIT;
      shadow_amp  <= A_INIT;
      wrap_cnt    <= '0;
      freq_out    <= F_INIT;
      amp_out     <= A_INIT;
      cfg_update  <= 1'b0;
      busy        <= 1'b0;
      req_a_ready <= 1'b1;
      req_b_ready <= 1'b1;
    end else begin
      cfg_update <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_a || grant_b) begin
            cmd_lat     <= grant_a ? req_a_cmd : req_b_cmd;
            // The pointer moves only after a contested grant.
            if (req_a_valid && req_b_valid) begin
              pref_b <= ~pref_b;
            end
            state       <= S_CALC;
            busy        <= 1'b1;
            req_a_ready <= 1'b0;
            req_b_ready <= 1'b0;
          end
        end
        S_CALC: begin
          shadow_freq <= calc_freq;
          shadow_amp  <= calc_amp;
          // Nothing visible would change, so skip the commit entirely.
          if ((calc_freq == freq_out) && (calc_amp == amp_out)) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            req_a_ready <= 1'b1;
            req_b_ready <= 1'b1;
          end else begin
            state    <= S_WAIT;
            wrap_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (phase_wrap || (wrap_cnt == CNT_LAST)) begin
            state      <= S_COMMIT;
            freq_out   <= shadow_freq;
            amp_out    <= shadow_amp;
            cfg_update <= 1'b1;
          end else begin
            wrap_cnt <= wrap_cnt + CNT_W'(1);
          end
        end
        S_COMMIT: begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          req_a_ready <= 1'b1;
          req_b_ready <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          req_a_ready <= 1'b1;
          req_b_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_cfg_sched.sv
// Self-checking bench for wave_cfg_sched. A behavioural model tracks the
// committed frequency/amplitude and the tie-break preference. Every
// transaction is then checked cycle by cycle against the expected commit and
// ready timing.
module tb_wave_cfg_sched;

  localparam int TMO = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a_valid, req_b_valid;
  logic [2:0] req_a_cmd, req_b_cmd;
  logic       req_a_ready, req_b_ready;
  logic       phase_wrap;
  logic [4:0] freq_out, amp_out;
  logic       cfg_update, busy;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int m_freq = 10;
  int m_amp  = 10;
  bit m_pref_b = 1'b0;

  wave_cfg_sched #(
    .FREQ_MIN(1), .FREQ_MAX(30), .FREQ_INIT(10),
    .AMP_MIN(10), .AMP_MAX(20), .AMP_INIT(10), .WRAP_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_a_valid(req_a_valid), .req_a_cmd(req_a_cmd), .req_a_ready(req_a_ready),
    .req_b_valid(req_b_valid), .req_b_cmd(req_b_cmd), .req_b_ready(req_b_ready),
    .phase_wrap(phase_wrap),
    .freq_out(freq_out), .amp_out(amp_out),
    .cfg_update(cfg_update), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int mstep(input int v, input int d, input int lo, input int hi);
    int r;
    r = v + d;
`ifdef WAVE_CFG_WRAP_EN
    if (r > hi) r = lo;
    if (r < lo) r = hi;
`else
    if (r > hi) r = hi;
    if (r < lo) r = lo;
`endif
    return r;
  endfunction

  task automatic model_next(input logic [2:0] cmd, output int f, output int a);
    f = m_freq;
    a = m_amp;
    case (cmd)
      3'd1: f = mstep(m_freq, 1, 1, 30);
      3'd2: f = mstep(m_freq, -1, 1, 30);
      3'd3: a = mstep(m_amp, 1, 10, 20);
      3'd4: a = mstep(m_amp, -1, 10, 20);
      3'd5: begin f = 10; a = 10; end
      default: ;
    endcase
  endtask

  // Called #1 after the accept edge. wrap_after >= 0: phase_wrap high for the
  // (wrap_after+1)-th WAIT cycle. -1: never. -2: one pulse during CALC only.
  task automatic serve(input logic [2:0] cmd, input int wrap_after, input string name);
    int ef, ea, exp_commit, exp_idle, n;
    bit change, exp_rdy, exp_upd, committed;
    model_next(cmd, ef, ea);
    change = (ef != m_freq) || (ea != m_amp);
    if (change) exp_commit = (wrap_after >= 0) ? 3 + wrap_after : 2 + TMO;
    else exp_commit = 0;
    exp_idle = change ? exp_commit + 1 : 2;
    n_vec += 2;
    if (req_a_ready !== 1'b0 || req_b_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s accept_ready: ready a=%b b=%b expected 0", name, req_a_ready, req_b_ready);
    end
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s accept_busy: busy=%b expected 1", name, busy);
    end
    for (int e = 1; e < exp_idle; e++) begin
      phase_wrap = ((wrap_after >= 0 && e == 2 + wrap_after) || (wrap_after == -2 && e == 1)) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      phase_wrap = 1'b0;
      n = e + 1;
      exp_rdy = (n >= exp_idle);
      exp_upd = change && (n == exp_commit);
      committed = change && (n >= exp_commit);
      n_vec += 5;
      if (req_a_ready !== exp_rdy || req_b_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL %s ready@%0d: a=%b b=%b expected %b", name, n, req_a_ready, req_b_ready, exp_rdy);
      end
      if (busy !== !exp_rdy) begin
        n_err++;
        $display("FAIL %s busy@%0d: busy=%b expected %b", name, n, busy, !exp_rdy);
      end
      if (cfg_update !== exp_upd) begin
        n_err++;
        $display("FAIL %s cfg_update@%0d: got %b expected %b", name, n, cfg_update, exp_upd);
      end
      if (freq_out !== 5'(committed ? ef : m_freq)) begin
        n_err++;
        $display("FAIL %s freq_out@%0d: got %0d expected %0d", name, n, freq_out, committed ? ef : m_freq);
      end
      if (amp_out !== 5'(committed ? ea : m_amp)) begin
        n_err++;
        $display("FAIL %s amp_out@%0d: got %0d expected %0d", name, n, amp_out, committed ? ea : m_amp);
      end
    end
    m_freq = ef;
    m_amp  = ea;
  endtask

  task automatic issue(input bit use_b, input logic [2:0] cmd, input int wrap_after, input string name);
    if (use_b) begin req_b_valid = 1'b1; req_b_cmd = cmd; end
    else begin req_a_valid = 1'b1; req_a_cmd = cmd; end
    @(posedge clk); #1;
    req_a_valid = 1'b0;
    req_b_valid = 1'b0;
    serve(cmd, wrap_after, name);
  endtask

  task automatic conflict(input logic [2:0] ca, input logic [2:0] cb, input string name);
    bit b_wins;
    b_wins = m_pref_b;
    req_a_valid = 1'b1; req_a_cmd = ca;
    req_b_valid = 1'b1; req_b_cmd = cb;
    @(posedge clk); #1;
    m_pref_b = ~m_pref_b;
    if (b_wins) begin
      req_b_valid = 1'b0;
      serve(cb, 0, {name, "_first_b"});
    end else begin
      req_a_valid = 1'b0;
      serve(ca, 0, {name, "_first_a"});
    end
    // loser has held valid and is taken on the first IDLE edge
    @(posedge clk); #1;
    req_a_valid = 1'b0;
    req_b_valid = 1'b0;
    if (b_wins) serve(ca, 1, {name, "_second_a"});
    else serve(cb, 1, {name, "_second_b"});
  endtask

  task automatic check_idle_outputs(input string name);
    n_vec += 4;
    if (freq_out !== 5'(m_freq) || amp_out !== 5'(m_amp)) begin
      n_err++;
      $display("FAIL %s outputs: freq=%0d amp=%0d expected %0d/%0d", name, freq_out, amp_out, m_freq, m_amp);
    end
    if (cfg_update !== 1'b0) begin
      n_err++;
      $display("FAIL %s cfg_update: got %b expected 0", name, cfg_update);
    end
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy: got %b expected 0", name, busy);
    end
    if (req_a_ready !== 1'b1 || req_b_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready: a=%b b=%b expected 1", name, req_a_ready, req_b_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_a_valid = 1'b0; req_b_valid = 1'b0;
    req_a_cmd = 3'd0; req_b_cmd = 3'd0;
    phase_wrap = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_freq = 10; m_amp = 10; m_pref_b = 1'b0;
    check_idle_outputs("reset");
  endtask

  task automatic test_basic;
    issue(1'b0, 3'd1, 2, "basic_freq_up");
    n_vec++;
    if (freq_out !== 5'd11 || amp_out !== 5'd10) begin
      n_err++;
      $display("FAIL basic_result: freq=%0d amp=%0d expected 11/10", freq_out, amp_out);
    end
  endtask

  task automatic test_conflict;
    issue(1'b0, 3'd5, 0, "conflict_prep");
    conflict(3'd3, 3'd2, "conflict1");
    conflict(3'd1, 3'd4, "conflict2");
  endtask

  task automatic test_saturate;
    issue(1'b1, 3'd5, 0, "sat_prep");
    for (int i = 0; i < 10; i++) issue(1'b1, 3'd3, i % 3, "amp_up_ten");
    n_vec++;
    if (amp_out !== 5'd20) begin
      n_err++;
      $display("FAIL amp_reaches_max: amp=%0d expected 20", amp_out);
    end
    issue(1'b1, 3'd3, 0, "amp_up_eleventh");
  endtask

  task automatic test_timeout;
    issue(1'b0, 3'd5, 0, "tmo_prep");
    issue(1'b0, 3'd2, -1, "timeout_freq_dn");
    issue(1'b1, 3'd1, -2, "timeout_calc_pulse");
    // strobe while idle must do nothing
    phase_wrap = 1'b1;
    @(posedge clk); #1;
    phase_wrap = 1'b0;
    check_idle_outputs("idle_wrap_1");
    @(posedge clk); #1;
    check_idle_outputs("idle_wrap_2");
  endtask

  task automatic test_defaults_nops;
    issue(1'b0, 3'd5, 0, "def_prep");
    for (int i = 0; i < 15; i++) issue(1'b0, 3'd1, 0, "to_freq25");
    for (int i = 0; i < 5; i++) issue(1'b1, 3'd3, 0, "to_amp15");
    n_vec++;
    if (freq_out !== 5'd25 || amp_out !== 5'd15) begin
      n_err++;
      $display("FAIL defaults_setup: freq=%0d amp=%0d expected 25/15", freq_out, amp_out);
    end
    issue(1'b1, 3'd5, 1, "defaults");
    issue(1'b0, 3'd0, 0, "nop0");
    issue(1'b1, 3'd6, 0, "nop6");
    issue(1'b0, 3'd7, 0, "nop7");
    issue(1'b0, 3'd5, 0, "defaults_again");
  endtask

  task automatic test_random;
    logic [2:0] c1, c2;
    for (int i = 0; i < 40; i++) begin
      c1 = 3'($urandom_range(0, 7));
      c2 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) conflict(c1, c2, "rand_conflict");
      else issue(1'($urandom_range(0, 1)), c1, $urandom_range(0, 5), "rand_cmd");
    end
  endtask

  task automatic test_reset_mid;
    issue(1'b0, 3'd5, 0, "mid_prep");
    issue(1'b0, 3'd1, 0, "mid_prep_up");
    req_b_valid = 1'b1; req_b_cmd = 3'd1;
    @(posedge clk); #1;
    req_b_valid = 1'b0;
    @(posedge clk); #1;              // now in WAIT_WRAP, no phase_wrap given
    req_b_valid = 1'b1; req_b_cmd = 3'd3;
    rst = 1'b1;
    #1;
    m_freq = 10; m_amp = 10; m_pref_b = 1'b0;
    check_idle_outputs("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;              // held B request accepted here
    req_b_valid = 1'b0;
    serve(3'd3, 0, "after_reset_b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_conflict();
    test_saturate();
    test_timeout();
    test_defaults_nops();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wave_cfg_sched.md
Name: wave_cfg_sched

Overview:
- Arbitrates sine-generator configuration requests from two sources: debounced board keys (requester A) and LCD touch keys (requester B).
- Keeps a shadow copy of output frequency step (×100 Hz) and amplitude (×0.1 Vpp).
- Commits changes to the DDS/scaling datapath only on a phase-wrap strobe, so the waveform never glitches mid-cycle.
- Sits between key_debounce/lcd_key_ctrl and freq_ctrl/multiplier chain; replaces separate per-source value/frequency counters.

Parameters:
- FREQ_MIN, 1, lowest frequency step (100 Hz)
- FREQ_MAX, 30, highest frequency step (3 kHz)
- FREQ_INIT, 10, frequency step after reset
- AMP_MIN, 10, lowest amplitude code (1.0 V)
- AMP_MAX, 20, highest amplitude code (2.0 V)
- AMP_INIT, 10, amplitude code after reset
- WRAP_TIMEOUT, 4096, max cycles to wait for phase_wrap before forced commit

Ports:
- clk  in  1  system clock (50 MHz domain)
- rst  in  1  asynchronous, active-high reset
- req_a_valid  in  1  requester A command valid
- req_a_cmd  in  3  requester A command
- req_a_ready  out  1  requester A may present a command
- req_b_valid  in  1  requester B command valid
- req_b_cmd  in  3  requester B command
- req_b_ready  out  1  requester B may present a command
- phase_wrap  in  1  one-cycle strobe at DDS phase zero, synchronous to clk
- freq_out  out  5  committed frequency step
- amp_out  out  5  committed amplitude code
- cfg_update  out  1  one-cycle pulse when freq_out/amp_out change
- busy  out  1  high outside IDLE

Behaviour:
- Single clock domain; reset is asynchronous and active-high.
- Command encoding:
  - 0 NOP
  - 1 FREQ_UP
  - 2 FREQ_DN
  - 3 AMP_UP
  - 4 AMP_DN
  - 5 DEFAULTS (load FREQ_INIT/AMP_INIT)
  - 6, 7 treated as NOP
- Reset values:
  - freq_out=FREQ_INIT, amp_out=AMP_INIT; shadow regs equal.
  - cfg_update=0, busy=0, ready outputs=1.
  - State IDLE; round-robin pointer favours A; timeout counter 0.
- FSM states: IDLE, CALC, WAIT_WRAP, COMMIT.
- IDLE:
  - req_a_ready=req_b_ready=1.
  - Transfer occurs when valid&ready at the rising edge.
  - Only one requester is accepted per edge. On simultaneous valid, the pointer decides; after a conflict grant, the pointer moves to the other requester.
  - The non-granted request is not consumed; the requester holds valid.
  - On accept: latch cmd, go to CALC.
- CALC (1 cycle):
  - Compute next shadow values. Up/down step by 1.
  - At a limit, saturate: FREQ_UP at FREQ_MAX stays FREQ_MAX; AMP_DN at AMP_MIN stays AMP_MIN.
  - If new shadow equals committed outputs (NOP, saturated, DEFAULTS when already default): return to IDLE, no cfg_update.
  - Otherwise go to WAIT_WRAP and clear the counter.
- WAIT_WRAP:
  - On phase_wrap=1 go to COMMIT.
  - Otherwise the counter increments; at WRAP_TIMEOUT-1 go to COMMIT (forced).
  - phase_wrap is sampled only in this state; strobes in IDLE/CALC are ignored.
- COMMIT (1 cycle):
  - freq_out/amp_out load shadow on entry edge; cfg_update=1 for this cycle only.
  - Next state IDLE.
- ready outputs are 0 in CALC, WAIT_WRAP and COMMIT. busy=1 in those states.
- Latency, accept to outputs:
  - Minimum 3 edges (accept → CALC → WAIT_WRAP with phase_wrap present → COMMIT).
  - Maximum 2+WRAP_TIMEOUT edges.
- Reset asserted mid-operation: pending command discarded, all outputs to reset values immediately (asynchronous).
- Arithmetic: 5-bit unsigned; limits compared before increment/decrement, never wraps through 0/31.

Optional Feature:
- Macro: WAVE_CFG_WRAP_EN.
- Defined: frequency and amplitude wrap at limits:
  - FREQ_UP at FREQ_MAX → FREQ_MIN; FREQ_DN at FREQ_MIN → FREQ_MAX.
  - Same for AMP.
  - Wrapped change always goes through WAIT_WRAP/COMMIT.
- Not defined: saturating behaviour as above.

Test Plan:
- Reset, then A FREQ_UP, phase_wrap 2 cycles after entering WAIT_WRAP → freq_out 10→11, amp_out 10, single cfg_update pulse; ready low exactly from accept until IDLE.
- A and B valid same edge (A=AMP_UP, B=FREQ_DN) → A served first (amp 11), then B served (freq 9); next conflict served to B first.
- Ten AMP_UP commands from B → amp_out reaches 20. An eleventh → no cfg_update, returns IDLE after CALC. With WAVE_CFG_WRAP_EN → amp_out=10 with cfg_update.
- FREQ_DN with phase_wrap held low → commit exactly WRAP_TIMEOUT cycles after entering WAIT_WRAP. phase_wrap pulse during IDLE → no effect.
- Command 5 after freq=25, amp=15 → outputs 10/10 in one commit. Commands 0, 6, 7 → no cfg_update.
- rst asserted while in WAIT_WRAP → outputs immediately 10/10, busy=0; after deassert, held B request is accepted on next edge.
